// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - minutes:seconds BCD countdown timer with blanking and expiry blink
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset
//   load     - capture ld_min/ld_sec (ignored while running)
//   ld_min   - binary minutes, clamped to 99
//   ld_sec   - binary seconds, clamped to 59
//   start    - begin/resume counting
//   pause    - freeze counting
//   dig      - {min_tens, min_ones, sec_tens, sec_ones} BCD nibbles
//   dig_en   - per-digit enables, bit3 = min_tens
//   running  - high while counting
//   done     - one-cycle pulse on reaching 00:00
module countdown_timer #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [6:0]  ld_min,
    input  logic [5:0]  ld_sec,
    input  logic        start,
    input  logic        pause,
    output logic [15:0] dig,
    output logic [3:0]  dig_en,
    output logic        running,
    output logic        done
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;
    logic [3:0]    dig_en_q, dig_en_d;
    logic          running_q, running_d;
    logic          done_q, done_d;

    logic [6:0]    min_c;
    logic [5:0]    sec_c;
    logic [15:0]   ld_bcd;
    logic [15:0]   dec_bcd;

    // Clamp first, then split into BCD digits.
    always_comb begin
        min_c  = (ld_min > 7'd99) ? 7'd99 : ld_min;
        sec_c  = (ld_sec > 6'd59) ? 6'd59 : ld_sec;
        ld_bcd = {4'(min_c / 7'd10), 4'(min_c % 7'd10),
                  4'(sec_c / 6'd10), 4'(sec_c % 6'd10)};
    end

    // One-second decrement with BCD borrow chain (seconds tens wrap to 5).
    always_comb begin
        dec_bcd = cnt_q;
        if (cnt_q[3:0] != 4'd0) begin
            dec_bcd[3:0] = cnt_q[3:0] - 4'd1;
        end else begin
            dec_bcd[3:0] = 4'd9;
            if (cnt_q[7:4] != 4'd0) begin
                dec_bcd[7:4] = cnt_q[7:4] - 4'd1;
            end else begin
                dec_bcd[7:4] = 4'd5;
                if (cnt_q[11:8] != 4'd0) begin
                    dec_bcd[11:8] = cnt_q[11:8] - 4'd1;
                end else begin
                    dec_bcd[11:8]  = 4'd9;
                    dec_bcd[15:12] = cnt_q[15:12] - 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        presc_d     = presc_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    cnt_d = ld_bcd;
                end else if (start && (cnt_q != 16'h0000)) begin
                    state_d = S_RUN;
                    presc_d = '0;
                end
            end
            S_RUN: begin
                // Pause beats a same-cycle tick; the prescaler holds even at
                // its terminal value so the tick fires right after resume.
                if (pause) begin
                    state_d = S_PAUSE;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    cnt_d   = dec_bcd;
                    if (dec_bcd == 16'h0000) begin
                        state_d     = S_DONE;
                        blink_cnt_d = '0;
                        blink_ph_d  = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            S_PAUSE: begin
                if (load) begin
                    cnt_d   = ld_bcd;
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (load) begin
                    cnt_d   = ld_bcd;
                    state_d = S_IDLE;
                end else if (blink_cnt_q == BLINK_MAX) begin
                    blink_cnt_d = '0;
                    blink_ph_d  = ~blink_ph_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are derived from next-state values so they register
        // alongside the state they describe.
        if (state_d == S_DONE) begin
            dig_en_d = {4{blink_ph_d}};
        end else begin
            dig_en_d = {(cnt_d[15:12] != 4'd0), 3'b111};
        end
        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE) && (state_q != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'h0000;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b1;
            dig_en_q    <= 4'b0111;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            dig_en_q    <= dig_en_d;
            running_q   <= running_d;
            done_q      <= done_d;
        end
    end

    assign dig     = cnt_q;
    assign dig_en  = dig_en_q;
    assign running = running_q;
    assign done    = done_q;

endmodule
